life_sequencer: RTL and testbench
=================================

# life_sequencer

Controller for the 8x8 Game of Life core. It sequences LFSR seeding, free-running evolution at a programmable generation rate, single-step debug and automatic halt on still-life or extinction. It drives the LFSR reset, the grid mux select and the grid register enable, and observes the current and next grid. It replaces the bare enable FSM in front of the evolve datapath.

## Interface
- TICK_DIV, 25_000_000: clock cycles per generation in RUN; must be ≥ 2
- GEN_W, 16: generation counter width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  run request, level, sampled in IDLE/PAUSE/HALT
- pause  in  1  pause request, level, sampled in RUN
- step  in  1  single-generation request, rising-edge detected, honoured only in PAUSE
- lfsr_begin  in  1  seed request; held high to keep capturing LFSR output
- grid_cur  in  64  registered grid (current generation)
- grid_next  in  64  combinational next generation from datapath
- lfsr_reset  out  1  high holds LFSR at seed
- sel_lfsr  out  1  grid mux select, 1 = LFSR output, 0 = grid_next
- grid_en  out  1  grid register load enable
- gen_count  out  GEN_W  generations evolved since last seed, saturating
- running  out  1  high in RUN
- stable  out  1  halted on still life
- extinct  out  1  halted on empty grid

## Operation
- States: IDLE, SEED, RUN, PAUSE, HALT.
- IDLE: lfsr_reset=1, grid_en=0. lfsr_begin → SEED (gen_count cleared). Otherwise start → RUN.
- SEED: lfsr_reset=0, sel_lfsr=1, grid_en=1 every cycle, so the grid tracks the LFSR. lfsr_begin low → PAUSE. The value captured on the last SEED edge is the seed.
- RUN: tick counter counts 0..TICK_DIV-1 and wraps. At terminal count: grid_en=1, sel_lfsr=0, gen_count+1 (held at 2^GEN_W-1 once reached).
  - On the same terminal cycle, grid_cur==0 → HALT with extinct=1.
  - Else grid_next==grid_cur → HALT with stable=1.
  - The load still occurs; it is harmless.
  - pause → PAUSE, with priority over everything, including a terminal tick: no load that cycle.
- PAUSE: start → RUN with counter cleared; start beats step. A step rising edge gives one cycle of grid_en=1 with sel_lfsr=0 and gen_count+1; the state stays PAUSE. Halt checks do not apply in PAUSE. lfsr_begin → SEED.
- HALT: grid frozen (grid_en=0), flags held.
  - lfsr_begin → SEED: clears flags and gen_count.
  - start → RUN: clears flags, keeps gen_count; lfsr_begin beats start.
- Outputs lfsr_reset, sel_lfsr, grid_en and running decode combinationally from state, tick counter and step edge. gen_count, stable and extinct are registered.

## Timing
- Reset: state=IDLE, tick counter=0, gen_count=0, stable=extinct=0, step_q=0.
  - Resulting outputs: lfsr_reset=1, sel_lfsr=0, grid_en=0, running=0.
- Reset mid-RUN or mid-SEED aborts in one edge. The grid register is not touched by this block.
- RUN generation latency: first load TICK_DIV cycles after entering RUN, then every TICK_DIV cycles.
- Step latency: grid_en is high in the cycle step is first seen high. The grid updates on the next edge.
- The halt decision uses grid_cur/grid_next in the terminal cycle. HALT state and the flag are visible one edge later.
- Holding step high yields exactly one generation. It must go low for at least one cycle before re-arming.

## Structure
- Package life_pkg: state_t enum {IDLE, SEED, RUN, PAUSE, HALT}, GRID_BITS=64, default TICK_DIV.
- Sub-module gen_tick: parameterised divider with synchronous clear and enable. It outputs a terminal-count pulse and is reusable for display refresh.
- The top-level game module instantiates life_sequencer in place of the bare FSM. Its grid_en feeds the grid flop enable, and sel_lfsr feeds the mux.

## Test plan
- Reset then idle 10 cycles → lfsr_reset=1, grid_en=0, gen_count=0, state IDLE.
- TICK_DIV=4, lfsr_begin high 3 cycles then low → grid_en high for exactly 3 cycles with sel_lfsr=1, then PAUSE. Start → grid_en pulses at cycles 4, 8, 12 after entry; gen_count=3 after 12 cycles.
- RUN with grid_cur=grid_next=64'h0000_0018_1800_0000 (block) → HALT after the first terminal tick, stable=1, grid_en stays 0 thereafter.
- RUN with grid_cur=0 → HALT with extinct=1 and stable=0. Start → RUN with flags cleared and gen_count unchanged.
- PAUSE, step held high 5 cycles → exactly one grid_en pulse and gen_count+1. Start and a step edge in the same cycle → RUN with no step load.
- pause asserted on a terminal-count cycle → no grid_en and gen_count unchanged. GEN_W=2 after 5 generations → gen_count=3.

Source files
------------

// File: rtl/life_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_pkg                                                             |
// | Shared types and constants for the Game of Life sequencer.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package life_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int GRID_BITS        = 64;
  localparam int TICK_DIV_DEFAULT = 25_000_000;

endpackage
`default_nettype wire

// File: rtl/life_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_sequencer_if                                                    |
// | Control/observe bundle between the sequencer and the grid datapath.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface life_sequencer_if
  import life_pkg::*;
#(
  parameter int GEN_W = 16
);
  logic                 start;
  logic                 pause;
  logic                 step;
  logic                 lfsr_begin;
  logic [GRID_BITS-1:0] grid_cur;
  logic [GRID_BITS-1:0] grid_next;
  logic                 lfsr_reset;
  logic                 sel_lfsr;
  logic                 grid_en;
  logic [GEN_W-1:0]     gen_count;
  logic                 running;
  logic                 stable;
  logic                 extinct;

  // master: the sequencer; slave: the grid core and user controls
  modport master (
    input  start, pause, step, lfsr_begin, grid_cur, grid_next,
    output lfsr_reset, sel_lfsr, grid_en, gen_count, running, stable, extinct
  );

  modport slave (
    output start, pause, step, lfsr_begin, grid_cur, grid_next,
    input  lfsr_reset, sel_lfsr, grid_en, gen_count, running, stable, extinct
  );

endinterface
`default_nettype wire

// File: rtl/gen_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_tick                                                             |
// | Modulo-DIV divider with clear/enable and a terminal-count pulse.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gen_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;
  logic          w_last;

  assign w_last = (count_q == C_LAST);
  assign o_tc   = i_en && !i_clr && w_last;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = w_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | life_sequencer                                                       |
// | Seeds, runs, steps and auto-halts the 8x8 Game of Life grid.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module life_sequencer
  import life_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  life_sequencer_if.master     bus
);

  state_t           state_d;
  state_t           state_q;
  logic [GEN_W-1:0] gen_count_d;
  logic [GEN_W-1:0] gen_count_q;
  logic             stable_d;
  logic             stable_q;
  logic             extinct_d;
  logic             extinct_q;
  logic             step_d;
  logic             step_q;

  logic             w_tc;
  logic             w_step_rise;
  logic             w_run_load;
  logic             w_step_load;
  logic [GEN_W-1:0] w_gen_inc;

  gen_tick #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (reset),
    .i_clr (state_q != RUN),
    .i_en  (state_q == RUN),
    .o_tc  (w_tc)
  );

  assign w_step_rise = bus.step && !step_q;
  assign w_gen_inc   = (gen_count_q == '1) ? gen_count_q : gen_count_q + 1'b1;

  // pause pre-empts a terminal tick; start or a reseed pre-empts a step
  assign w_run_load  = (state_q == RUN) && w_tc && !bus.pause;
  assign w_step_load = (state_q == PAUSE) && w_step_rise && !bus.start && !bus.lfsr_begin;

  assign bus.lfsr_reset = (state_q == IDLE);
  assign bus.sel_lfsr   = (state_q == SEED);
  assign bus.grid_en    = (state_q == SEED) || w_run_load || w_step_load;
  assign bus.running    = (state_q == RUN);
  assign bus.gen_count  = gen_count_q;
  assign bus.stable     = stable_q;
  assign bus.extinct    = extinct_q;

  always_comb begin
    state_d     = state_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    extinct_d   = extinct_q;
    step_d      = bus.step;
    case (state_q)
      IDLE: begin
        if (bus.lfsr_begin) begin
          state_d     = SEED;
          gen_count_d = '0;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      SEED: begin
        if (!bus.lfsr_begin) begin
          state_d = PAUSE;
        end
      end
      RUN: begin
        if (bus.pause) begin
          state_d = PAUSE;
        end else if (w_tc) begin
          gen_count_d = w_gen_inc;
          // the halting generation is still loaded; it equals the current grid
          if (bus.grid_cur == '0) begin
            state_d   = HALT;
            extinct_d = 1'b1;
          end else if (bus.grid_next == bus.grid_cur) begin
            state_d  = HALT;
            stable_d = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (bus.start) begin
          state_d = RUN;
        end else if (bus.lfsr_begin) begin
          state_d     = SEED;
          gen_count_d = '0;
        end else if (w_step_rise) begin
          gen_count_d = w_gen_inc;
        end
      end
      HALT: begin
        if (bus.lfsr_begin) begin
          state_d     = SEED;
          gen_count_d = '0;
          stable_d    = 1'b0;
          extinct_d   = 1'b0;
        end else if (bus.start) begin
          state_d   = RUN;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      extinct_q   <= extinct_d;
      step_q      <= step_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_life_sequencer                                                    |
// | Directed self-checking bench, TICK_DIV=4 and GEN_W=2.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_life_sequencer;

  localparam int C_DIV   = 4;
  localparam int C_GEN_W = 2;
  localparam logic [63:0] C_BLOCK = 64'h0000_0018_1800_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cnt;
  logic [11:0] mask;

  life_sequencer_if #(.GEN_W(C_GEN_W)) bus ();

  life_sequencer #(
    .TICK_DIV (C_DIV),
    .GEN_W    (C_GEN_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.step       = 1'b0;
    bus.lfsr_begin = 1'b0;
    bus.grid_cur   = 64'h1;
    bus.grid_next  = 64'h2;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_lfsr_reset", 64'(bus.lfsr_reset), 64'd1);
    chk("rst_grid_en",    64'(bus.grid_en),    64'd0);
    chk("rst_sel_lfsr",   64'(bus.sel_lfsr),   64'd0);
    chk("rst_running",    64'(bus.running),    64'd0);
    chk("rst_flags",      64'({bus.stable, bus.extinct}), 64'd0);

    for (int i = 0; i < 10; i++) tick();
    chk("idle_lfsr_reset", 64'(bus.lfsr_reset), 64'd1);
    chk("idle_grid_en",    64'(bus.grid_en),    64'd0);
    chk("idle_gen",        64'(bus.gen_count),  64'd0);

    // seed: lfsr_begin high for three cycles
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      bus.lfsr_begin = (i < 3);
      #1;
      if (bus.grid_en && bus.sel_lfsr) cnt++;
      tick();
    end
    chk("seed_en_cycles", 64'(cnt), 64'd3);
    chk("seed_pause_lfsr_reset", 64'(bus.lfsr_reset), 64'd0);
    chk("seed_pause_running",    64'(bus.running),    64'd0);
    chk("seed_gen",              64'(bus.gen_count),  64'd0);

    // run: loads on the 4th, 8th and 12th cycle after entry
    bus.start = 1'b1;
    #1;
    chk("start_no_load", 64'(bus.grid_en), 64'd0);
    tick();
    bus.start = 1'b0;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      mask[i] = bus.grid_en && !bus.sel_lfsr;
      tick();
      if (i == 3) chk("run_gen1", 64'(bus.gen_count), 64'd1);
    end
    chk("run_load_pattern", 64'(mask), 64'h888);
    chk("run_gen3",         64'(bus.gen_count), 64'd3);
    chk("run_running",      64'(bus.running),   64'd1);

    // still life halts on the next terminal tick
    bus.grid_cur  = C_BLOCK;
    bus.grid_next = C_BLOCK;
    tick();
    tick();
    tick();
    chk("block_tc_en",     64'(bus.grid_en), 64'd1);
    chk("block_tc_stable", 64'(bus.stable),  64'd0);
    tick();
    chk("block_halt_running", 64'(bus.running), 64'd0);
    chk("block_stable",       64'(bus.stable),  64'd1);
    chk("block_extinct",      64'(bus.extinct), 64'd0);
    chk("block_gen_sat",      64'(bus.gen_count), 64'd3);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.grid_en) cnt++;
      tick();
    end
    chk("halt_frozen", 64'(cnt), 64'd0);

    // reseed from HALT
    bus.lfsr_begin = 1'b1;
    tick();
    bus.lfsr_begin = 1'b0;
    #1;
    chk("reseed_sel",   64'(bus.sel_lfsr),  64'd1);
    chk("reseed_flags", 64'({bus.stable, bus.extinct}), 64'd0);
    chk("reseed_gen",   64'(bus.gen_count), 64'd0);
    tick();

    // extinction wins over still life
    bus.grid_cur  = 64'h0;
    bus.grid_next = 64'h0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ext_extinct", 64'(bus.extinct),   64'd1);
    chk("ext_stable",  64'(bus.stable),    64'd0);
    chk("ext_running", 64'(bus.running),   64'd0);
    chk("ext_gen",     64'(bus.gen_count), 64'd1);
    bus.grid_cur  = 64'h1;
    bus.grid_next = 64'h2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    chk("restart_running", 64'(bus.running),   64'd1);
    chk("restart_flags",   64'({bus.stable, bus.extinct}), 64'd0);
    chk("restart_gen",     64'(bus.gen_count), 64'd1);

    // pause on terminal cycle suppresses the load
    tick();
    tick();
    tick();
    bus.pause = 1'b1;
    #1;
    chk("pause_tc_no_load", 64'(bus.grid_en), 64'd0);
    tick();
    bus.pause = 1'b0;
    #1;
    chk("pause_running", 64'(bus.running),   64'd0);
    chk("pause_gen",     64'(bus.gen_count), 64'd1);

    // held step gives exactly one generation
    bus.step = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.grid_en && !bus.sel_lfsr) cnt++;
      tick();
    end
    bus.step = 1'b0;
    chk("step_pulses", 64'(cnt), 64'd1);
    tick();
    chk("step_gen", 64'(bus.gen_count), 64'd2);

    // start beats a simultaneous step edge
    bus.step  = 1'b1;
    bus.start = 1'b1;
    #1;
    chk("start_step_no_load", 64'(bus.grid_en), 64'd0);
    tick();
    bus.step  = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("start_step_running", 64'(bus.running),   64'd1);
    chk("start_step_gen",     64'(bus.gen_count), 64'd2);

    // saturation at 2^GEN_W-1
    for (int i = 0; i < 4; i++) tick();
    chk("sat_gen3", 64'(bus.gen_count), 64'd3);
    for (int i = 0; i < 8; i++) tick();
    chk("sat_gen5", 64'(bus.gen_count), 64'd3);

    // reset mid-run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrun_rst_running",    64'(bus.running),    64'd0);
    chk("midrun_rst_lfsr_reset", 64'(bus.lfsr_reset), 64'd1);
    chk("midrun_rst_gen",        64'(bus.gen_count),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
